// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode types, opcodes and the queued decode entry (M ops used only with DECODE_RV32M_EN).
package cpu_pkg;
  localparam int MAX_XLEN = 64;
  localparam int MAX_PC_W = 64;
  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  typedef enum logic [4:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;
  typedef enum logic [1:0] {SRC_A_RS1, SRC_A_ZERO, SRC_A_PC} src_a_sel_t;
  typedef enum logic {SRC_B_RS2, SRC_B_IMM} src_b_sel_t;
  typedef enum logic {WRITE_DISABLE, WRITE_ENABLE} reg_write_t;
  typedef struct packed {
    alu_op_t alu_op;
    src_a_sel_t src_a_sel;
    src_b_sel_t src_b_sel;
    reg_write_t reg_write;
  } control_signals_t;
  localparam control_signals_t CTRL_NOP = '{ALU_NOP, SRC_A_RS1, SRC_B_RS2, WRITE_DISABLE};
  // imm and pc are stored at maximum width; the stage truncates to XLEN / PC_W
  typedef struct packed {
    control_signals_t ctrl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [MAX_XLEN-1:0] imm;
    logic [MAX_PC_W-1:0] pc;
    logic illegal;
  } decoded_entry_t;
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(parameter int XLEN = 32, parameter int PC_W = 32);
  import cpu_pkg::*;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_instr;
  logic [PC_W-1:0] in_pc;
  logic out_valid;
  logic out_ready;
  control_signals_t out_ctrl;
  logic [4:0] out_rd;
  logic [4:0] out_rs1;
  logic [4:0] out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [PC_W-1:0] out_pc;
  logic out_illegal;
  modport master(
    output flush, in_valid, in_instr, in_pc, out_ready,
    input in_ready, out_valid, out_ctrl, out_rd, out_rs1, out_rs2, out_imm, out_pc, out_illegal
  );
  modport slave(
    input flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_rd, out_rs1, out_rs2, out_imm, out_pc, out_illegal
  );
endinterface

// File: rtl/instr_decode.sv
// instr_decode: combinational RV32I instruction to decoded_entry_t; DECODE_RV32M_EN adds the M extension.
module instr_decode import cpu_pkg::*; #(parameter int XLEN = 32) (
  input logic [31:0] instr,
  input logic [MAX_PC_W-1:0] pc,
  output decoded_entry_t entry
);
  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_u, shamt, imm;
  alu_op_t alu;
  src_a_sel_t src_a;
  src_b_sel_t src_b;
  logic ill;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign shamt = XLEN'(instr[24:20]);
  always_comb begin
    alu = ALU_NOP;
    src_a = SRC_A_RS1;
    src_b = SRC_B_RS2;
    imm = '0;
    ill = 1'b1;
    if (op == OPCODE_OP) begin
      ill = 1'b0;
      case ({f7, f3})
        {7'h00, 3'd0}: alu = ALU_ADD;
        {7'h20, 3'd0}: alu = ALU_SUB;
        {7'h00, 3'd1}: alu = ALU_SLL;
        {7'h00, 3'd2}: alu = ALU_SLT;
        {7'h00, 3'd3}: alu = ALU_SLTU;
        {7'h00, 3'd4}: alu = ALU_XOR;
        {7'h00, 3'd5}: alu = ALU_SRL;
        {7'h20, 3'd5}: alu = ALU_SRA;
        {7'h00, 3'd6}: alu = ALU_OR;
        {7'h00, 3'd7}: alu = ALU_AND;
`ifdef DECODE_RV32M_EN
        {7'h01, 3'd0}: alu = ALU_MUL;
        {7'h01, 3'd1}: alu = ALU_MULH;
        {7'h01, 3'd2}: alu = ALU_MULHSU;
        {7'h01, 3'd3}: alu = ALU_MULHU;
        {7'h01, 3'd4}: alu = ALU_DIV;
        {7'h01, 3'd5}: alu = ALU_DIVU;
        {7'h01, 3'd6}: alu = ALU_REM;
        {7'h01, 3'd7}: alu = ALU_REMU;
`endif
        default: ill = 1'b1;
      endcase
    end else if (op == OPCODE_OP_IMM) begin
      src_b = SRC_B_IMM;
      imm = imm_i;
      ill = 1'b0;
      case (f3)
        3'd0: alu = ALU_ADD;
        3'd1: begin alu = ALU_SLL; imm = shamt; ill = f7 != 7'h00; end
        3'd2: alu = ALU_SLT;
        3'd3: alu = ALU_SLTU;
        3'd4: alu = ALU_XOR;
        3'd5: begin alu = f7[5] ? ALU_SRA : ALU_SRL; imm = shamt; ill = (f7 & 7'h5f) != 7'h00; end
        3'd6: alu = ALU_OR;
        3'd7: alu = ALU_AND;
      endcase
    end else if (op == OPCODE_LUI || op == OPCODE_AUIPC) begin
      alu = ALU_ADD;
      src_a = op == OPCODE_AUIPC ? SRC_A_PC : SRC_A_ZERO;
      src_b = SRC_B_IMM;
      imm = imm_u;
      ill = 1'b0;
    end
  end
  // illegal entries carry a neutral control word so execute treats them as bubbles
  assign entry = '{
    ctrl: ill ? CTRL_NOP : control_signals_t'{alu, src_a, src_b, instr[11:7] != 5'd0 ? WRITE_ENABLE : WRITE_DISABLE},
    rd: instr[11:7],
    rs1: instr[19:15],
    rs2: instr[24:20],
    imm: ill ? '0 : MAX_XLEN'(imm),
    pc: pc,
    illegal: ill
  };
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with a DEPTH-entry in-order output queue, flush and valid/ready on both sides.
module decode_stage import cpu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  decode_stage_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  decoded_entry_t mem [DEPTH];
  decoded_entry_t dec, head_e;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic push, pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  instr_decode #(.XLEN(XLEN)) u_dec (.instr(bus.in_instr), .pc(MAX_PC_W'(bus.in_pc)), .entry(dec));
  // ready depends only on registered count, so a full queue cannot accept even while popping
  assign bus.in_ready = count < CW'(DEPTH);
  assign bus.out_valid = count != '0;
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop = bus.out_valid && bus.out_ready;
  assign head_e = mem[head];
  assign bus.out_ctrl = head_e.ctrl;
  assign bus.out_rd = head_e.rd;
  assign bus.out_rs1 = head_e.rs1;
  assign bus.out_rs2 = head_e.rs2;
  assign bus.out_imm = head_e.imm[XLEN-1:0];
  assign bus.out_pc = head_e.pc[PC_W-1:0];
  assign bus.out_illegal = head_e.illegal;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) mem[tail] <= dec;
      if (push) tail <= nxt(tail);
      if (pop) head <= nxt(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
